// File: rtl/usrt_csr_pkg.sv
// ---------------------------------------------------------------------------
// usrt_csr_pkg : register map, bit positions and bus FSM states for the USRT CSR bank
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package usrt_csr_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_IER    = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int CTRL_BAUD_LSB = 0;
  localparam int CTRL_PAR_EN   = 2;
  localparam int CTRL_PAR_ODD  = 3;
  localparam int CTRL_TX_EN    = 4;
  localparam int CTRL_RX_EN    = 5;

  localparam int ST_TX_BUSY = 0;
  localparam int ST_RX_FULL = 1;
  localparam int ST_RX_DONE = 2;
  localparam int ST_TX_DONE = 3;
  localparam int ST_PAR_ERR = 4;
  localparam int ST_OVERRUN = 5;

  localparam logic [5:0] W1C_MASK   = 6'b111100;
  localparam logic [5:0] CTRL_RST   = 6'h00;
  localparam logic [5:0] IER_RST    = 6'h00;
  localparam logic [5:0] STICKY_RST = 6'h00;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_SETUP  = 2'd1,
    BUS_ACCESS = 2'd2
  } bus_state_e;

endpackage

`default_nettype wire

// File: rtl/usrt_csr_if.sv
// ---------------------------------------------------------------------------
// usrt_csr_if : APB-style peripheral bus between the bridge and the CSR bank
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface usrt_csr_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              i_Psel;
  logic              i_Enable;
  logic              i_Pwrite;
  logic [ADDR_W-1:0] i_Addr;
  logic [DATA_W-1:0] i_Data;
  logic [DATA_W-1:0] o_Rdata;
  logic              o_Ready;

  modport master (
    output i_Psel, i_Enable, i_Pwrite, i_Addr, i_Data,
    input  o_Rdata, o_Ready
  );

  modport slave (
    input  i_Psel, i_Enable, i_Pwrite, i_Addr, i_Data,
    output o_Rdata, o_Ready
  );
endinterface

`default_nettype wire

// File: rtl/usrt_csr_chan.sv
// ---------------------------------------------------------------------------
// usrt_csr_chan : one channel's CTRL/STATUS/IER, edge detectors and interrupt
// Rev 1.0 -- IER and interrupt present only when USRT_CSR_IRQ_EN is defined
// ---------------------------------------------------------------------------
`default_nettype none

module usrt_csr_chan
  import usrt_csr_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_ctrl_i,
  input  logic       wr_status_i,
  input  logic       wr_ier_i,
  input  logic [5:0] wdata_i,
  input  logic       tx_busy_i,
  input  logic       rx_full_i,
  input  logic       parity_err_i,
  output logic [5:0] ctrl_o,
  output logic [5:0] status_o,
  output logic [5:0] ier_o,
  output logic       irq_o
);

  logic [5:0] ctrl_q, ctrl_d;
  logic [5:0] sticky_q, sticky_d;
  logic [5:0] set_w, clr_w;
  logic       tx_busy_q, rx_full_q;
  logic       rx_rise_w, tx_fall_w;

  assign rx_rise_w = rx_full_i & ~rx_full_q;
  assign tx_fall_w = tx_busy_q & ~tx_busy_i;

  // Set is OR-ed in after the clear so a same-cycle event survives a W1C.
  always_comb begin
    set_w             = '0;
    set_w[ST_RX_DONE] = rx_rise_w;
    set_w[ST_TX_DONE] = tx_fall_w;
    set_w[ST_PAR_ERR] = parity_err_i;
    set_w[ST_OVERRUN] = rx_rise_w & sticky_q[ST_RX_DONE];
    clr_w             = wr_status_i ? (wdata_i & W1C_MASK) : 6'h00;
    sticky_d          = ((sticky_q & ~clr_w) | set_w) & W1C_MASK;
    ctrl_d            = wr_ctrl_i ? wdata_i : ctrl_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q    <= CTRL_RST;
      sticky_q  <= STICKY_RST;
      tx_busy_q <= 1'b0;
      rx_full_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      sticky_q  <= sticky_d;
      tx_busy_q <= tx_busy_i;
      rx_full_q <= rx_full_i;
    end
  end

  always_comb begin
    status_o             = sticky_q;
    status_o[ST_TX_BUSY] = tx_busy_i;
    status_o[ST_RX_FULL] = rx_full_i;
  end

  assign ctrl_o = ctrl_q;

`ifdef USRT_CSR_IRQ_EN
  logic [5:0] ier_q;
  logic       irq_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ier_q <= IER_RST;
      irq_q <= 1'b0;
    end else begin
      if (wr_ier_i) begin
        ier_q <= wdata_i & W1C_MASK;
      end
      irq_q <= |(sticky_q & ier_q);
    end
  end

  assign ier_o = ier_q;
  assign irq_o = irq_q;
`else
  logic unused_ier_w;
  assign unused_ier_w = wr_ier_i;
  assign ier_o        = IER_RST;
  assign irq_o        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/usrt_csr_bank.sv
// ---------------------------------------------------------------------------
// usrt_csr_bank : APB-style CSR bank for NUM_CH USRT channels (bus FSM, decode, read mux)
// Rev 1.0 -- optional interrupt support via USRT_CSR_IRQ_EN
// ---------------------------------------------------------------------------
`default_nettype none

module usrt_csr_bank
  import usrt_csr_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int WAIT_CYC = 0
) (
  input  logic                i_Pclk,
  input  logic                i_Reset,
  usrt_csr_if.slave           bus,
  input  logic [NUM_CH-1:0]   i_Tx_Busy,
  input  logic [NUM_CH-1:0]   i_Rx_Full,
  input  logic [NUM_CH-1:0]   i_Parity_Err,
  output logic [2*NUM_CH-1:0] o_Baud_Sel,
  output logic [NUM_CH-1:0]   o_Parity_En,
  output logic [NUM_CH-1:0]   o_Parity_Odd,
  output logic [NUM_CH-1:0]   o_Tx_En,
  output logic [NUM_CH-1:0]   o_Rx_En,
  output logic [NUM_CH-1:0]   o_Irq
);

  localparam logic [1:0] C_WAIT = 2'(WAIT_CYC);
  localparam int         CH_W   = ADDR_W - 2;

  bus_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        off_w;
  logic [CH_W-1:0]   ch_w;
  logic              ch_ok_w, commit_w;
  logic [5:0]        rd_w;
  logic [5:0]        ctrl_w   [NUM_CH];
  logic [5:0]        status_w [NUM_CH];
  logic [5:0]        ier_w    [NUM_CH];
  logic [NUM_CH-1:0] wr_ctrl_w, wr_status_w, wr_ier_w;
  logic              unused_w;

  assign off_w    = bus.i_Addr[1:0];
  assign ch_w     = bus.i_Addr[ADDR_W-1:2];
  assign ch_ok_w  = 32'(ch_w) < 32'(NUM_CH);
  assign unused_w = ^bus.i_Data[DATA_W-1:6];

  // o_Ready is high for the last access cycle; the write lands on the edge that ends it.
  assign commit_w = ready_q & bus.i_Pwrite & ch_ok_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      BUS_IDLE: begin
        if (bus.i_Psel && bus.i_Enable) begin
          state_d = BUS_ACCESS;
          cnt_d   = 2'd0;
        end else if (bus.i_Psel) begin
          state_d = BUS_SETUP;
        end
      end
      BUS_SETUP: begin
        if (bus.i_Enable) begin
          state_d = BUS_ACCESS;
          cnt_d   = 2'd0;
        end else if (!bus.i_Psel) begin
          state_d = BUS_IDLE;
        end
      end
      BUS_ACCESS: begin
        if (cnt_q == C_WAIT) begin
          state_d = (bus.i_Psel && !bus.i_Enable) ? BUS_SETUP : BUS_IDLE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = BUS_IDLE;
    endcase
    ready_d = (state_d == BUS_ACCESS) && (cnt_d == C_WAIT);
    rdata_d = (ready_d && !bus.i_Pwrite) ? DATA_W'(rd_w) : '0;
  end

  always_comb begin
    rd_w = 6'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_w == CH_W'(i)) begin
        case (off_w)
          OFF_CTRL:   rd_w = ctrl_w[i];
          OFF_STATUS: rd_w = status_w[i];
          OFF_IER:    rd_w = ier_w[i];
          OFF_RSVD:   rd_w = 6'h00;
          default:    rd_w = 6'h00;
        endcase
      end
    end
  end

  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= BUS_IDLE;
      cnt_q   <= 2'd0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.o_Ready = ready_q;
  assign bus.o_Rdata = rdata_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign wr_ctrl_w[i]   = commit_w && (ch_w == CH_W'(i)) && (off_w == OFF_CTRL);
    assign wr_status_w[i] = commit_w && (ch_w == CH_W'(i)) && (off_w == OFF_STATUS);
    assign wr_ier_w[i]    = commit_w && (ch_w == CH_W'(i)) && (off_w == OFF_IER);

    usrt_csr_chan u_chan (
      .clk_i        (i_Pclk),
      .rst_i        (i_Reset),
      .wr_ctrl_i    (wr_ctrl_w[i]),
      .wr_status_i  (wr_status_w[i]),
      .wr_ier_i     (wr_ier_w[i]),
      .wdata_i      (bus.i_Data[5:0]),
      .tx_busy_i    (i_Tx_Busy[i]),
      .rx_full_i    (i_Rx_Full[i]),
      .parity_err_i (i_Parity_Err[i]),
      .ctrl_o       (ctrl_w[i]),
      .status_o     (status_w[i]),
      .ier_o        (ier_w[i]),
      .irq_o        (o_Irq[i])
    );

    assign o_Baud_Sel[2*i +: 2] = ctrl_w[i][CTRL_BAUD_LSB +: 2];
    assign o_Parity_En[i]       = ctrl_w[i][CTRL_PAR_EN];
    assign o_Parity_Odd[i]      = ctrl_w[i][CTRL_PAR_ODD];
    assign o_Tx_En[i]           = ctrl_w[i][CTRL_TX_EN];
    assign o_Rx_En[i]           = ctrl_w[i][CTRL_RX_EN];
  end

endmodule

`default_nettype wire

// File: tb/tb_usrt_csr_bank.sv
// ---------------------------------------------------------------------------
// tb_usrt_csr_bank : directed self-checking bench, one zero-wait and one 3-wait instance
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_usrt_csr_bank;

`ifdef USRT_CSR_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst0, rst3;
  always #5 clk = ~clk;

  usrt_csr_if #(.DATA_W(8), .ADDR_W(5)) bus0 ();
  usrt_csr_if #(.DATA_W(8), .ADDR_W(5)) bus3 ();

  logic [1:0] tx0, rx0, pe0, tx3, rx3, pe3;
  logic [3:0] baud0, baud3;
  logic [1:0] pen0, podd0, txen0, rxen0, irq0;
  logic [1:0] pen3, podd3, txen3, rxen3, irq3;

  usrt_csr_bank #(.NUM_CH(2), .DATA_W(8), .ADDR_W(5), .WAIT_CYC(0)) u_dut0 (
    .i_Pclk(clk), .i_Reset(rst0), .bus(bus0),
    .i_Tx_Busy(tx0), .i_Rx_Full(rx0), .i_Parity_Err(pe0),
    .o_Baud_Sel(baud0), .o_Parity_En(pen0), .o_Parity_Odd(podd0),
    .o_Tx_En(txen0), .o_Rx_En(rxen0), .o_Irq(irq0)
  );

  usrt_csr_bank #(.NUM_CH(2), .DATA_W(8), .ADDR_W(5), .WAIT_CYC(3)) u_dut3 (
    .i_Pclk(clk), .i_Reset(rst3), .bus(bus3),
    .i_Tx_Busy(tx3), .i_Rx_Full(rx3), .i_Parity_Err(pe3),
    .o_Baud_Sel(baud3), .o_Parity_En(pen3), .o_Parity_Odd(podd3),
    .o_Tx_En(txen3), .o_Rx_En(rxen3), .o_Irq(irq3)
  );

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] rd;
  int         waits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic xfer0(input logic wr, input logic [4:0] a, input logic [7:0] wd,
                       output logic [7:0] d, output int w);
    logic got;
    got = 1'b0;
    d   = 8'h00;
    w   = 0;
    @(posedge clk); #1;
    bus0.i_Psel = 1'b1; bus0.i_Enable = 1'b0; bus0.i_Pwrite = wr;
    bus0.i_Addr = a;    bus0.i_Data = wd;
    @(posedge clk); #1;
    bus0.i_Enable = 1'b1;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(posedge clk); #1;
      if (bus0.o_Ready === 1'b1) begin
        got = 1'b1;
        d   = bus0.o_Rdata;
        w   = k;
      end
    end
    chk("ready_seen", {31'd0, got}, 1);
    @(posedge clk); #1;
    bus0.i_Psel = 1'b0; bus0.i_Enable = 1'b0; bus0.i_Pwrite = 1'b0;
    chk("ready_released", {31'd0, bus0.o_Ready}, 0);
    chk("rdata_idle", {24'd0, bus0.o_Rdata}, 0);
  endtask

  task automatic wr0(input logic [4:0] a, input logic [7:0] wd);
    logic [7:0] dummy;
    int         w;
    xfer0(1'b1, a, wd, dummy, w);
  endtask

  task automatic rd0(input logic [4:0] a, output logic [7:0] d);
    int w;
    xfer0(1'b0, a, 8'h00, d, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.i_Psel = 0; bus0.i_Enable = 0; bus0.i_Pwrite = 0; bus0.i_Addr = 0; bus0.i_Data = 0;
    bus3.i_Psel = 0; bus3.i_Enable = 0; bus3.i_Pwrite = 0; bus3.i_Addr = 0; bus3.i_Data = 0;
    tx0 = 0; rx0 = 0; pe0 = 0; tx3 = 0; rx3 = 0; pe3 = 0;
    rst0 = 1'b1; rst3 = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst0 = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;

    chk("rst_ready", {31'd0, bus0.o_Ready}, 0);
    chk("rst_rdata", {24'd0, bus0.o_Rdata}, 0);
    chk("rst_baud", {28'd0, baud0}, 0);
    chk("rst_ctrl_bits", {24'd0, pen0, podd0, txen0, rxen0}, 0);
    chk("rst_irq", {30'd0, irq0}, 0);

    // CTRL ch1 = 0x0D: baud 01, parity enabled odd, tx/rx disabled
    xfer0(1'b1, 5'd4, 8'h0D, rd, waits);
    chk("wr_latency", waits, 1);
    chk("baud", {28'd0, baud0}, 32'h4);
    chk("par_en", {30'd0, pen0}, 32'h2);
    chk("par_odd", {30'd0, podd0}, 32'h2);
    chk("tx_en", {30'd0, txen0}, 0);
    chk("rx_en", {30'd0, rxen0}, 0);
    rd0(5'd4, rd); chk("ctrl1_rb", {24'd0, rd}, 32'h0D);
    rd0(5'd0, rd); chk("ctrl0_rb", {24'd0, rd}, 0);

    tx0[0] = 1'b1;
    repeat (2) @(posedge clk); #1;
    rd0(5'd1, rd); chk("st_busy", {24'd0, rd}, 32'h01);
    tx0[0] = 1'b0;
    repeat (2) @(posedge clk); #1;
    rd0(5'd1, rd); chk("st_txdone", {24'd0, rd}, 32'h08);
    wr0(5'd1, 8'h08);
    rd0(5'd1, rd); chk("st_w1c", {24'd0, rd}, 0);

    wr0(5'd2, 8'h20);
    rd0(5'd2, rd); chk("ier_rb", {24'd0, rd}, IRQ_ON ? 32'h20 : 32'h00);
    @(posedge clk); #1; rx0[0] = 1'b1;
    @(posedge clk); #1; rx0[0] = 1'b0;
    @(posedge clk); #1; rx0[0] = 1'b1;
    @(posedge clk); #1; chk("irq_pre", {31'd0, irq0[0]}, 0);
    @(posedge clk); #1; chk("irq_overrun", {31'd0, irq0[0]}, {31'd0, IRQ_ON});
    rd0(5'd1, rd); chk("st_overrun", {24'd0, rd}, 32'h26);
    wr0(5'd1, 8'h3C);
    rx0[0] = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("irq_clear", {31'd0, irq0[0]}, 0);
    rd0(5'd1, rd); chk("st_cleared", {24'd0, rd}, 0);

    // W1C of parity_err on the same edge as a new parity pulse
    @(posedge clk); #1;
    bus0.i_Psel = 1'b1; bus0.i_Enable = 1'b0; bus0.i_Pwrite = 1'b1;
    bus0.i_Addr = 5'd1; bus0.i_Data = 8'h10;
    @(posedge clk); #1; bus0.i_Enable = 1'b1;
    @(posedge clk); #1;
    chk("w1c_ready", {31'd0, bus0.o_Ready}, 1);
    pe0[0] = 1'b1;
    @(posedge clk); #1;
    pe0[0] = 1'b0; bus0.i_Psel = 1'b0; bus0.i_Enable = 1'b0; bus0.i_Pwrite = 1'b0;
    rd0(5'd1, rd); chk("w1c_set_wins", {24'd0, rd}, 32'h10);
    wr0(5'd1, 8'h10);
    rd0(5'd1, rd); chk("w1c_plain", {24'd0, rd}, 0);

    wr0(5'd20, 8'hFF);
    wr0(5'd3, 8'hFF);
    rd0(5'd4, rd);  chk("ctrl1_after_oor", {24'd0, rd}, 32'h0D);
    rd0(5'd0, rd);  chk("ctrl0_after_oor", {24'd0, rd}, 0);
    rd0(5'd20, rd); chk("oor_rdata", {24'd0, rd}, 0);
    rd0(5'd3, rd);  chk("rsvd_rdata", {24'd0, rd}, 0);

    // Three wait states: ready on the fourth access cycle
    @(posedge clk); #1;
    bus3.i_Psel = 1'b1; bus3.i_Enable = 1'b0; bus3.i_Pwrite = 1'b1;
    bus3.i_Addr = 5'd0; bus3.i_Data = 8'h3F;
    @(posedge clk); #1; bus3.i_Enable = 1'b1;
    waits = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (bus3.o_Ready === 1'b1) begin
        waits = k;
        break;
      end
    end
    chk("wait3_latency", waits, 4);
    chk("wait3_no_early_commit", {28'd0, baud3}, 0);
    @(posedge clk); #1;
    bus3.i_Psel = 1'b0; bus3.i_Enable = 1'b0; bus3.i_Pwrite = 1'b0;
    chk("wait3_commit_baud", {28'd0, baud3}, 32'h3);
    chk("wait3_commit_txen", {30'd0, txen3}, 32'h1);

    @(posedge clk); #1;
    bus3.i_Psel = 1'b1; bus3.i_Enable = 1'b0; bus3.i_Pwrite = 1'b1;
    bus3.i_Addr = 5'd4; bus3.i_Data = 8'h3F;
    @(posedge clk); #1; bus3.i_Enable = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("abort_ready_before", {31'd0, bus3.o_Ready}, 1);
    rst3 = 1'b1;
    #1;
    chk("abort_ready_async", {31'd0, bus3.o_Ready}, 0);
    #1;
    rst3 = 1'b0;
    bus3.i_Psel = 1'b0; bus3.i_Enable = 1'b0; bus3.i_Pwrite = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("abort_no_commit_baud", {28'd0, baud3}, 0);
    chk("abort_no_commit_txen", {30'd0, txen3}, 0);
    chk("abort_irq3", {30'd0, irq3}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
